// File: rtl/id_ex_skid_reg.sv
// ID/EX pipeline register with a valid/ready handshake and a two-entry skid buffer.
// The main entry drives execute. The skid entry absorbs one bundle while execute stalls.
module id_ex_skid_reg #(
  parameter int   DATA_W    = 8,
  parameter int   INST_W    = 8,
  parameter int   JADR_W    = 6,
  parameter logic PCSRC_RST = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] PCline_in,
  input  logic [INST_W-1:0] inst_code_in,
  input  logic [DATA_W-1:0] ImmData_in,
  input  logic [DATA_W-1:0] Read_Data_1,
  input  logic [JADR_W-1:0] j_adr_in,
  input  logic [2:0]        ctrl_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] PCline_out,
  output logic [INST_W-1:0] inst_code_out,
  output logic [DATA_W-1:0] ImmData_out,
  output logic [DATA_W-1:0] num1,
  output logic [JADR_W-1:0] j_adr_out,
  output logic [2:0]        ctrl_out,
  output logic [1:0]        occupancy
);

  localparam int BUN_W = 3*DATA_W + INST_W + JADR_W + 3;

  logic [BUN_W-1:0] r_main;
  logic [BUN_W-1:0] r_skid;
  logic             r_main_valid;
  logic             r_skid_valid;

  logic [BUN_W-1:0] w_in_bundle;
  logic [2:0]       w_main_ctrl;
  logic             w_accept;
  logic             w_drain;

  assign w_in_bundle = {PCline_in, inst_code_in, ImmData_in, Read_Data_1, j_adr_in, ctrl_in};

  // in_ready depends only on registered state, so out_ready never reaches it combinationally.
  assign in_ready  = ~r_skid_valid;
  assign out_valid = r_main_valid;
  assign w_accept  = in_valid & in_ready;
  assign w_drain   = r_main_valid & out_ready;

  // The skid entry is only ever filled while main is full, so an empty main implies an empty skid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_main       <= '0;
      r_skid       <= '0;
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (flush) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (!r_main_valid) begin
      if (w_accept) begin
        r_main       <= w_in_bundle;
        r_main_valid <= 1'b1;
      end
    end else if (r_skid_valid) begin
      if (w_drain) begin
        r_main       <= r_skid;
        r_skid_valid <= 1'b0;
      end
    end else begin
      if (w_drain && w_accept) begin
        r_main <= w_in_bundle;
      end else if (w_drain) begin
        r_main_valid <= 1'b0;
      end else if (w_accept) begin
        r_skid       <= w_in_bundle;
        r_skid_valid <= 1'b1;
      end
    end
  end

  assign {PCline_out, inst_code_out, ImmData_out, num1, j_adr_out, w_main_ctrl} = r_main;

  // Bubbles present a safe control word: no register write, default PC source.
  assign ctrl_out  = r_main_valid ? w_main_ctrl : {PCSRC_RST, 2'b00};
  assign occupancy = {1'b0, r_main_valid} + {1'b0, r_skid_valid};

endmodule

// File: tb/tb_id_ex_skid_reg.sv
// Directed bench for id_ex_skid_reg: default instance plus a wide instance with PCSRC_RST=0.
module tb_id_ex_skid_reg;

  logic clk;
  logic reset;

  logic       flush, in_valid, in_ready, out_valid, out_ready;
  logic [7:0] pc_in, inst_in, imm_in, rd1, pc_out, inst_out, imm_out, num1;
  logic [5:0] jadr_in, jadr_out;
  logic [2:0] ctrl_in, ctrl_out;
  logic [1:0] occ;

  logic        w_flush, w_in_valid, w_in_ready, w_out_valid, w_out_ready;
  logic [15:0] w_pc_in, w_imm_in, w_rd1, w_pc_out, w_imm_out, w_num1;
  logic [7:0]  w_inst_in, w_inst_out;
  logic [9:0]  w_jadr_in, w_jadr_out;
  logic [2:0]  w_ctrl_in, w_ctrl_out;
  logic [1:0]  w_occ;

  int n_tests = 0;
  int n_fail  = 0;

  id_ex_skid_reg u_dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .PCline_in(pc_in), .inst_code_in(inst_in), .ImmData_in(imm_in), .Read_Data_1(rd1),
    .j_adr_in(jadr_in), .ctrl_in(ctrl_in), .out_valid(out_valid), .out_ready(out_ready),
    .PCline_out(pc_out), .inst_code_out(inst_out), .ImmData_out(imm_out), .num1(num1),
    .j_adr_out(jadr_out), .ctrl_out(ctrl_out), .occupancy(occ)
  );

  id_ex_skid_reg #(.DATA_W(16), .INST_W(8), .JADR_W(10), .PCSRC_RST(1'b0)) u_dut_w (
    .clk(clk), .reset(reset), .flush(w_flush), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .PCline_in(w_pc_in), .inst_code_in(w_inst_in), .ImmData_in(w_imm_in), .Read_Data_1(w_rd1),
    .j_adr_in(w_jadr_in), .ctrl_in(w_ctrl_in), .out_valid(w_out_valid), .out_ready(w_out_ready),
    .PCline_out(w_pc_out), .inst_code_out(w_inst_out), .ImmData_out(w_imm_out), .num1(w_num1),
    .j_adr_out(w_jadr_out), .ctrl_out(w_ctrl_out), .occupancy(w_occ)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    pc_in = '0; inst_in = '0; imm_in = '0; rd1 = '0; jadr_in = '0; ctrl_in = '0;
    w_flush = 1'b0; w_in_valid = 1'b0; w_out_ready = 1'b0;
    w_pc_in = '0; w_inst_in = '0; w_imm_in = '0; w_rd1 = '0; w_jadr_in = '0; w_ctrl_in = '0;

    cyc(); cyc();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_occ",       32'(occ),       32'd0);
    chk("rst_ctrl",      32'(ctrl_out),  32'h4);
    chk("rst_num1",      32'(num1),      32'h0);
    chk("rst_w_ctrl",    32'(w_ctrl_out), 32'h0);
    chk("rst_w_valid",   32'(w_out_valid), 32'd0);

    // streaming at full rate
    reset = 1'b1; out_ready = 1'b1; in_valid = 1'b1; ctrl_in = 3'b011;
    rd1 = 8'h11; pc_in = 8'h40; inst_in = 8'h5A; imm_in = 8'h7E; jadr_in = 6'h2B;
    cyc();
    chk("str_num1_11", 32'(num1), 32'h11);
    chk("str_valid_1", 32'(out_valid), 32'd1);
    chk("str_pc",      32'(pc_out), 32'h40);
    chk("str_inst",    32'(inst_out), 32'h5A);
    chk("str_imm",     32'(imm_out), 32'h7E);
    chk("str_jadr",    32'(jadr_out), 32'h2B);
    chk("str_ctrl",    32'(ctrl_out), 32'h3);
    rd1 = 8'h22;
    cyc();
    chk("str_num1_22", 32'(num1), 32'h22);
    chk("str_valid_2", 32'(out_valid), 32'd1);
    chk("str_occ_2",   32'(occ), 32'd1);
    rd1 = 8'h33;
    cyc();
    chk("str_num1_33", 32'(num1), 32'h33);
    chk("str_ready_3", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    cyc();
    chk("str_end_valid", 32'(out_valid), 32'd0);
    chk("str_end_ctrl",  32'(ctrl_out), 32'h4);
    chk("str_end_occ",   32'(occ), 32'd0);

    // stall fill into the skid entry
    out_ready = 1'b0; in_valid = 1'b1; rd1 = 8'hA1;
    cyc();
    chk("stl_num1_a1", 32'(num1), 32'hA1);
    chk("stl_occ_1",   32'(occ), 32'd1);
    chk("stl_ready_1", 32'(in_ready), 32'd1);
    rd1 = 8'hA2;
    cyc();
    chk("stl_occ_2",   32'(occ), 32'd2);
    chk("stl_ready_0", 32'(in_ready), 32'd0);
    chk("stl_hold_a1", 32'(num1), 32'hA1);
    rd1 = 8'hB0;
    cyc();
    chk("stl_noacc_occ", 32'(occ), 32'd2);
    chk("stl_noacc_a1",  32'(num1), 32'hA1);
    in_valid = 1'b0; out_ready = 1'b1;
    cyc();
    chk("drn_num1_a2", 32'(num1), 32'hA2);
    chk("drn_occ_1",   32'(occ), 32'd1);
    chk("drn_ready",   32'(in_ready), 32'd1);
    cyc();
    chk("drn_valid_0", 32'(out_valid), 32'd0);
    chk("drn_occ_0",   32'(occ), 32'd0);

    // flush with both entries held
    out_ready = 1'b0; in_valid = 1'b1; rd1 = 8'hC1; ctrl_in = 3'b011;
    cyc();
    rd1 = 8'hC2;
    cyc();
    chk("fl_occ_2", 32'(occ), 32'd2);
    flush = 1'b1; rd1 = 8'hFF;
    cyc();
    chk("fl_valid", 32'(out_valid), 32'd0);
    chk("fl_occ",   32'(occ), 32'd0);
    chk("fl_ctrl",  32'(ctrl_out), 32'h4);
    chk("fl_ready", 32'(in_ready), 32'd1);
    // flush while a bundle is actually accepted
    flush = 1'b0; rd1 = 8'hD1;
    cyc();
    chk("fl1_occ_1", 32'(occ), 32'd1);
    flush = 1'b1; rd1 = 8'hFF;
    cyc();
    chk("fl1_occ_0", 32'(occ), 32'd0);
    flush = 1'b0; in_valid = 1'b0;
    cyc();
    chk("fl1_no_ff", 32'(out_valid), 32'd0);

    // async reset between edges while stalled
    out_ready = 1'b0; in_valid = 1'b1; rd1 = 8'hE1;
    cyc();
    rd1 = 8'hE2;
    cyc();
    chk("ar_occ_2", 32'(occ), 32'd2);
    in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("ar_valid", 32'(out_valid), 32'd0);
    chk("ar_occ",   32'(occ), 32'd0);
    chk("ar_ready", 32'(in_ready), 32'd1);
    chk("ar_num1",  32'(num1), 32'h0);
    chk("ar_ctrl",  32'(ctrl_out), 32'h4);
    cyc();
    reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1; rd1 = 8'hF1;
    cyc();
    chk("ar_post_num1", 32'(num1), 32'hF1);
    chk("ar_post_occ",  32'(occ), 32'd1);
    in_valid = 1'b0;
    cyc();

    // wide instance with PCSRC_RST=0
    w_out_ready = 1'b1; w_in_valid = 1'b1; w_rd1 = 16'hBEEF; w_imm_in = 16'h1234;
    w_pc_in = 16'hABCD; w_jadr_in = 10'h3A5; w_inst_in = 8'h9C; w_ctrl_in = 3'b111;
    cyc();
    chk("w_num1", 32'(w_num1), 32'hBEEF);
    chk("w_imm",  32'(w_imm_out), 32'h1234);
    chk("w_pc",   32'(w_pc_out), 32'hABCD);
    chk("w_jadr", 32'(w_jadr_out), 32'h3A5);
    chk("w_inst", 32'(w_inst_out), 32'h9C);
    chk("w_ctrl", 32'(w_ctrl_out), 32'h7);
    w_in_valid = 1'b0;
    cyc();
    chk("w_bub_valid", 32'(w_out_valid), 32'd0);
    chk("w_bub_ctrl",  32'(w_ctrl_out), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
